// File: rtl/bpu_pkg.sv
// Shared types and helpers for the gshare branch prediction unit.
package bpu_pkg;

  // Control-flow type stored per BTB entry and carried with each resolve.
  typedef enum logic [1:0] {
    BR   = 2'd0,
    JMP  = 2'd1,
    CALL = 2'd2,
    RET  = 2'd3
  } br_type_e;

  // 2-bit saturating counter step: strongly/weakly not-taken 00/01, weakly/strongly taken 10/11.
  function automatic logic [1:0] sat2_next(input logic [1:0] c, input logic taken);
    if (taken) return (c == 2'b11) ? c : c + 2'b01;
    else       return (c == 2'b00) ? c : c - 2'b01;
  endfunction

endpackage

// File: rtl/bpu_ras.sv
// Circular return address stack with a {cnt, ptr} checkpoint.
// ptr names the next free slot; top is the slot just below it.
// A restore loads {cnt, ptr} first and the same-cycle push/pop is applied on top of it.
module bpu_ras #(
  parameter int DEPTH  = 4,
  parameter int W      = 32,
  parameter int PTR_W  = $clog2(DEPTH),
  parameter int CKPT_W = 2*PTR_W+1
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              push,
  input  logic              pop,
  input  logic [W-1:0]      push_val,
  input  logic              restore,
  input  logic [CKPT_W-1:0] restore_val,
  output logic [CKPT_W-1:0] ckpt_out,
  output logic [W-1:0]      top
);

  logic [W-1:0]     stack [DEPTH];
  logic [PTR_W:0]   cnt;
  logic [PTR_W-1:0] ptr;
  logic [PTR_W:0]   base_cnt;
  logic [PTR_W-1:0] base_ptr;

  assign ckpt_out = {cnt, ptr};
  assign top      = stack[ptr - 1'b1];

  // Select the state the push/pop acts on: live pointers or the checkpoint being restored.
  always_comb begin
    base_cnt = cnt;
    base_ptr = ptr;
    if (restore) begin
      base_cnt = restore_val[CKPT_W-1:PTR_W];
      base_ptr = restore_val[PTR_W-1:0];
    end
  end

  // Push overwrites the oldest entry when full (cnt saturates); pop on empty holds state.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      cnt <= '0;
      ptr <= '0;
      for (int i = 0; i < DEPTH; i++) stack[i] <= '0;
    end else if (push) begin
      stack[base_ptr] <= push_val;
      ptr <= base_ptr + 1'b1;
      cnt <= (base_cnt >= (PTR_W+1)'(DEPTH)) ? base_cnt : base_cnt + 1'b1;
    end else if (pop && (base_cnt != '0)) begin
      ptr <= base_ptr - 1'b1;
      cnt <= base_cnt - 1'b1;
    end else begin
      ptr <= base_ptr;
      cnt <= base_cnt;
    end
  end

endmodule

// File: rtl/bpu_gshare.sv
// Fetch-stage branch predictor: tagged BTB, gshare PHT and a return address stack.
// f_valid qualifies f_pc and r_valid qualifies all r_* inputs; there is no back-pressure,
// so a valid fetch or resolve is consumed in the cycle it is presented.
module bpu_gshare
  import bpu_pkg::*;
#(
  parameter int PC_W       = 32,
  parameter int BTB_LOG    = 9,
  parameter int TAG_W      = 8,
  parameter int PHT_LOG    = 10,
  parameter int GHR_W      = 8,
  parameter int RAS_DEPTH  = 4,
  parameter int RAS_CKPT_W = 2*$clog2(RAS_DEPTH)+1
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  f_valid,
  input  logic [PC_W-1:0]       f_pc,
  output logic                  f_hit,
  output logic                  f_pred_taken,
  output logic [PC_W-1:0]       f_pred_target,
  output logic [GHR_W-1:0]      f_ghr,
  output logic [RAS_CKPT_W-1:0] f_ras_ckpt,
  input  logic                  r_valid,
  input  logic [PC_W-1:0]       r_pc,
  input  br_type_e              r_type,
  input  logic                  r_taken,
  input  logic [PC_W-1:0]       r_target,
  input  logic                  r_pred_taken,
  input  logic [PC_W-1:0]       r_pred_target,
  input  logic [GHR_W-1:0]      r_ghr,
  input  logic [RAS_CKPT_W-1:0] r_ras_ckpt,
  output logic                  mispredict,
  output logic [PC_W-1:0]       redirect_pc
);

  localparam int BTB_N     = 1 << BTB_LOG;
  localparam int PHT_N     = 1 << PHT_LOG;
  localparam int RAS_PTR_W = $clog2(RAS_DEPTH);

  logic [BTB_N-1:0] btb_valid;
  logic [TAG_W-1:0] btb_tag    [BTB_N];
  logic [PC_W-1:0]  btb_target [BTB_N];
  br_type_e         btb_type   [BTB_N];
  logic [1:0]       pht        [PHT_N];
  logic [GHR_W-1:0] ghr;

  logic [BTB_LOG-1:0] f_btb_idx, r_btb_idx;
  logic [TAG_W-1:0]   f_tag, r_tag;
  logic [PHT_LOG-1:0] f_pht_idx, r_pht_idx;
  br_type_e           hit_type;
  logic               fetch_upd;
  logic               ras_nonempty;
  logic [PC_W-1:0]    ras_top;
  logic               ras_push, ras_pop;
  logic [PC_W-1:0]    ras_push_val;
  logic               unused_pc_bits;

  assign f_btb_idx = f_pc[BTB_LOG+1:2];
  assign f_tag     = f_pc[BTB_LOG+TAG_W+1:BTB_LOG+2];
  assign f_pht_idx = f_pc[PHT_LOG+1:2] ^ PHT_LOG'(ghr);
  assign r_btb_idx = r_pc[BTB_LOG+1:2];
  assign r_tag     = r_pc[BTB_LOG+TAG_W+1:BTB_LOG+2];
  assign r_pht_idx = r_pc[PHT_LOG+1:2] ^ PHT_LOG'(r_ghr);
  assign unused_pc_bits = ^{f_pc, r_pc};

  assign hit_type     = btb_type[f_btb_idx];
  assign f_hit        = btb_valid[f_btb_idx] && (btb_tag[f_btb_idx] == f_tag);
  assign f_ghr        = ghr;
  assign ras_nonempty = f_ras_ckpt[RAS_CKPT_W-1:RAS_PTR_W] != '0;

  assign mispredict  = r_valid & ((r_taken != r_pred_taken) |
                                  (r_taken & (r_target != r_pred_target)));
  assign redirect_pc = r_taken ? r_target : r_pc + PC_W'(4);
  assign fetch_upd   = f_valid & f_hit & ~mispredict;

  // Prediction: fall-through on a miss, PHT direction for BRs, RAS top for RETs when available.
  always_comb begin
    f_pred_taken  = 1'b0;
    f_pred_target = f_pc + PC_W'(4);
    if (f_hit) begin
      f_pred_taken  = (hit_type == BR) ? pht[f_pht_idx][1] : 1'b1;
      f_pred_target = (hit_type == RET && ras_nonempty) ? ras_top : btb_target[f_btb_idx];
    end
  end

  // RAS control: recovery replays the resolved CALL/RET on the checkpoint, else fetch speculates.
  always_comb begin
    ras_push     = fetch_upd & (hit_type == CALL);
    ras_pop      = fetch_upd & (hit_type == RET);
    ras_push_val = f_pc + PC_W'(4);
    if (mispredict) begin
      ras_push     = (r_type == CALL);
      ras_pop      = (r_type == RET);
      ras_push_val = r_pc + PC_W'(4);
    end
  end

  // Speculative GHR: recovery from the checkpoint takes priority over a fetch-time shift.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      ghr <= '0;
    end else if (mispredict) begin
      ghr <= (r_type == BR) ? {r_ghr[GHR_W-2:0], r_taken} : r_ghr;
    end else if (fetch_upd && hit_type == BR) begin
      ghr <= {ghr[GHR_W-2:0], f_pred_taken};
    end
  end

  // Table training from resolve: PHT counters for BRs, BTB allocate/overwrite on taken.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      btb_valid <= '0;
      for (int i = 0; i < PHT_N; i++) pht[i] <= 2'b01;
    end else if (r_valid) begin
      if (r_type == BR) pht[r_pht_idx] <= sat2_next(pht[r_pht_idx], r_taken);
      if (r_taken) begin
        btb_valid[r_btb_idx]  <= 1'b1;
        btb_tag[r_btb_idx]    <= r_tag;
        btb_target[r_btb_idx] <= r_target;
        btb_type[r_btb_idx]   <= r_type;
      end
    end
  end

  bpu_ras #(
    .DEPTH  (RAS_DEPTH),
    .W      (PC_W),
    .PTR_W  (RAS_PTR_W),
    .CKPT_W (RAS_CKPT_W)
  ) u_ras (
    .clk         (clk),
    .nrst        (nrst),
    .push        (ras_push),
    .pop         (ras_pop),
    .push_val    (ras_push_val),
    .restore     (mispredict),
    .restore_val (r_ras_ckpt),
    .ckpt_out    (f_ras_ckpt),
    .top         (ras_top)
  );

endmodule

// File: tb/tb_bpu_gshare.sv
// Bench for bpu_gshare: directed vector table, hand sequences for RAS overflow,
// recovery-vs-fetch priority and mid-run reset, then random traffic against a model.
module tb_bpu_gshare;
  import bpu_pkg::*;

  logic        clk, nrst;
  logic        f_valid;
  logic [31:0] f_pc;
  logic        f_hit, f_pred_taken;
  logic [31:0] f_pred_target;
  logic [7:0]  f_ghr;
  logic [4:0]  f_ras_ckpt;
  logic        r_valid;
  logic [31:0] r_pc;
  br_type_e    r_type;
  logic        r_taken;
  logic [31:0] r_target;
  logic        r_pred_taken;
  logic [31:0] r_pred_target;
  logic [7:0]  r_ghr;
  logic [4:0]  r_ras_ckpt;
  logic        mispredict;
  logic [31:0] redirect_pc;

  int checks = 0;
  int failures = 0;

  bpu_gshare dut (
    .clk(clk), .nrst(nrst), .f_valid(f_valid), .f_pc(f_pc), .f_hit(f_hit),
    .f_pred_taken(f_pred_taken), .f_pred_target(f_pred_target), .f_ghr(f_ghr),
    .f_ras_ckpt(f_ras_ckpt), .r_valid(r_valid), .r_pc(r_pc), .r_type(r_type),
    .r_taken(r_taken), .r_target(r_target), .r_pred_taken(r_pred_taken),
    .r_pred_target(r_pred_target), .r_ghr(r_ghr), .r_ras_ckpt(r_ras_ckpt),
    .mispredict(mispredict), .redirect_pc(redirect_pc)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct { logic [31:0] pc; logic [31:0] tgt; int typ; } btb_e;
  btb_e        m_btb[int];
  int          m_pht[1024];
  int          m_ghr;
  logic [31:0] m_ras[4];
  int          m_cnt, m_ptr;

  function automatic int btb_slot(input logic [31:0] pc);
    return int'((pc >> 2) % 512);
  endfunction

  function automatic int tag_of(input logic [31:0] pc);
    return int'((pc >> 11) % 256);
  endfunction

  function automatic int pht_slot(input logic [31:0] pc, input int g);
    return int'((pc >> 2) % 1024) ^ g;
  endfunction

  function automatic void predict(input logic [31:0] pc, output bit hit, output bit pt,
                                  output logic [31:0] tgt, output int typ);
    int s;
    s = btb_slot(pc);
    hit = 0; pt = 0; tgt = pc + 32'd4; typ = 0;
    if (m_btb.exists(s) && tag_of(m_btb[s].pc) == tag_of(pc)) begin
      hit = 1;
      typ = m_btb[s].typ;
      tgt = m_btb[s].tgt;
      pt  = (typ == 0) ? (m_pht[pht_slot(pc, m_ghr)] >= 2) : 1'b1;
      if (typ == 3 && m_cnt > 0) tgt = m_ras[(m_ptr + 3) % 4];
    end
  endfunction

  function automatic bit model_misp();
    return r_valid && ((r_taken != r_pred_taken) || (r_taken && r_target != r_pred_target));
  endfunction

  function automatic void ras_push(input logic [31:0] v);
    m_ras[m_ptr] = v;
    m_ptr = (m_ptr + 1) % 4;
    m_cnt = (m_cnt + 1 > 4) ? 4 : m_cnt + 1;
  endfunction

  function automatic void ras_pop();
    if (m_cnt > 0) begin
      m_ptr = (m_ptr + 3) % 4;
      m_cnt = m_cnt - 1;
    end
  endfunction

  function automatic void model_step();
    bit hit, pt;
    logic [31:0] tgt;
    int typ, k;
    if (!nrst) begin
      m_btb.delete();
      foreach (m_pht[i]) m_pht[i] = 1;
      foreach (m_ras[i]) m_ras[i] = '0;
      m_ghr = 0; m_cnt = 0; m_ptr = 0;
      return;
    end
    predict(f_pc, hit, pt, tgt, typ);
    if (model_misp()) begin
      m_ghr = (r_type == BR) ? (((int'(r_ghr) << 1) | int'(r_taken)) & 255) : int'(r_ghr);
      m_cnt = int'(r_ras_ckpt) >> 2;
      m_ptr = int'(r_ras_ckpt) & 3;
      if (r_type == CALL) ras_push(r_pc + 32'd4);
      else if (r_type == RET) ras_pop();
    end else if (f_valid && hit) begin
      if (typ == 0) m_ghr = ((m_ghr << 1) | int'(pt)) & 255;
      else if (typ == 2) ras_push(f_pc + 32'd4);
      else if (typ == 3) ras_pop();
    end
    if (r_valid) begin
      if (r_type == BR) begin
        k = pht_slot(r_pc, int'(r_ghr));
        if (r_taken) m_pht[k] = (m_pht[k] == 3) ? 3 : m_pht[k] + 1;
        else         m_pht[k] = (m_pht[k] == 0) ? 0 : m_pht[k] - 1;
      end
      if (r_taken) m_btb[btb_slot(r_pc)] = '{pc: r_pc, tgt: r_target, typ: int'(r_type)};
    end
  endfunction

  // ---------------- checking ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h @%0t", nm, act, exp, $time);
    end
  endtask

  // Compare all outputs against the model state (called away from the rising edge).
  task automatic check_model();
    bit hit, pt;
    logic [31:0] tgt;
    int typ;
    predict(f_pc, hit, pt, tgt, typ);
    chk("m_f_hit", 32'(f_hit), 32'(hit));
    chk("m_f_pred_taken", 32'(f_pred_taken), 32'(pt));
    chk("m_f_pred_target", f_pred_target, tgt);
    chk("m_f_ghr", 32'(f_ghr), 32'(m_ghr));
    chk("m_f_ras_ckpt", 32'(f_ras_ckpt), 32'((m_cnt << 2) | m_ptr));
    chk("m_mispredict", 32'(mispredict), 32'(model_misp()));
    chk("m_redirect_pc", redirect_pc, r_taken ? r_target : r_pc + 32'd4);
  endtask

  task automatic advance();
    @(posedge clk);
    model_step();
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_fetch(input logic fv, input logic [31:0] pc);
    f_valid = fv;
    f_pc    = pc;
  endtask

  task automatic set_res(input logic rv, input logic [31:0] pc, input int typ, input logic tk,
                         input logic [31:0] tgt, input logic pt, input logic [31:0] ptgt,
                         input logic [7:0] g, input logic [4:0] ck);
    logic [1:0] t2;
    t2 = typ[1:0];
    r_valid = rv; r_pc = pc; r_type = br_type_e'(t2); r_taken = tk; r_target = tgt;
    r_pred_taken = pt; r_pred_target = ptgt; r_ghr = g; r_ras_ckpt = ck;
  endtask

  task automatic idle_res();
    set_res(1'b0, 32'h0, 0, 1'b0, 32'h0, 1'b0, 32'h0, 8'h0, 5'h0);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic fv; logic [31:0] fpc;
    logic rv; logic [31:0] rpc; int rtype; logic rtk; logic [31:0] rtgt;
    logic rpt; logic [31:0] rptgt; logic [7:0] rghr; logic [4:0] rck;
    logic e_hit; logic e_pt; logic [31:0] e_tgt; logic [7:0] e_ghr;
    logic e_misp; logic [31:0] e_redir;
  } vec_t;

  vec_t vecs[9];
  logic [31:0] pool[16];
  logic [31:0] ret_exp[5];

  initial begin
    // fields: fv fpc | rv rpc type tk tgt pt ptgt ghr ck | hit pt tgt ghr misp redir
    vecs[0] = '{1'b1, 32'h100, 1'b0, 32'h0,   0, 1'b0, 32'h0,   1'b0, 32'h0, 8'h00, 5'd0,
                1'b0, 1'b0, 32'h104, 8'h00, 1'b0, 32'h4};
    vecs[1] = '{1'b0, 32'h100, 1'b1, 32'h100, 0, 1'b1, 32'h80,  1'b0, 32'h0, 8'h00, 5'd0,
                1'b0, 1'b0, 32'h104, 8'h00, 1'b1, 32'h80};
    vecs[2] = '{1'b1, 32'h100, 1'b0, 32'h0,   0, 1'b0, 32'h0,   1'b0, 32'h0, 8'h00, 5'd0,
                1'b1, 1'b0, 32'h80,  8'h01, 1'b0, 32'h4};
    vecs[3] = '{1'b0, 32'h0,   1'b1, 32'h200, 2, 1'b1, 32'h400, 1'b0, 32'h0, 8'h02, 5'd0,
                1'b0, 1'b0, 32'h4,   8'h02, 1'b1, 32'h400};
    vecs[4] = '{1'b0, 32'h0,   1'b1, 32'h480, 3, 1'b1, 32'h0,   1'b0, 32'h0, 8'h02, 5'd5,
                1'b0, 1'b0, 32'h4,   8'h02, 1'b1, 32'h0};
    vecs[5] = '{1'b1, 32'h200, 1'b0, 32'h0,   0, 1'b0, 32'h0,   1'b0, 32'h0, 8'h00, 5'd0,
                1'b1, 1'b1, 32'h400, 8'h02, 1'b0, 32'h4};
    vecs[6] = '{1'b1, 32'h480, 1'b0, 32'h0,   0, 1'b0, 32'h0,   1'b0, 32'h0, 8'h00, 5'd0,
                1'b1, 1'b1, 32'h204, 8'h02, 1'b0, 32'h4};
    vecs[7] = '{1'b1, 32'h480, 1'b0, 32'h0,   0, 1'b0, 32'h0,   1'b0, 32'h0, 8'h00, 5'd0,
                1'b1, 1'b1, 32'h0,   8'h02, 1'b0, 32'h4};
    vecs[8] = '{1'b1, 32'h900, 1'b0, 32'h0,   0, 1'b0, 32'h0,   1'b0, 32'h0, 8'h00, 5'd0,
                1'b0, 1'b0, 32'h904, 8'h02, 1'b0, 32'h4};

    ret_exp = '{32'h1044, 32'h1034, 32'h1024, 32'h1014, 32'h7770};
    pool = '{32'h100, 32'h104, 32'h108, 32'h10c, 32'h900, 32'h200, 32'h204, 32'h480,
             32'h484, 32'h1000, 32'h1004, 32'h3000, 32'h40100, 32'h500, 32'h504, 32'h508};

    // Reset
    nrst = 1'b0;
    set_fetch(1'b0, 32'h0);
    idle_res();
    repeat (2) advance();
    nrst = 1'b1;

    // Directed table
    for (int i = 0; i < 9; i++) begin
      set_fetch(vecs[i].fv, vecs[i].fpc);
      set_res(vecs[i].rv, vecs[i].rpc, vecs[i].rtype, vecs[i].rtk, vecs[i].rtgt,
              vecs[i].rpt, vecs[i].rptgt, vecs[i].rghr, vecs[i].rck);
      @(negedge clk);
      check_model();
      chk($sformatf("v%0d_f_hit", i), 32'(f_hit), 32'(vecs[i].e_hit));
      chk($sformatf("v%0d_f_pred_taken", i), 32'(f_pred_taken), 32'(vecs[i].e_pt));
      chk($sformatf("v%0d_f_pred_target", i), f_pred_target, vecs[i].e_tgt);
      chk($sformatf("v%0d_f_ghr", i), 32'(f_ghr), 32'(vecs[i].e_ghr));
      chk($sformatf("v%0d_mispredict", i), 32'(mispredict), 32'(vecs[i].e_misp));
      chk($sformatf("v%0d_redirect_pc", i), redirect_pc, vecs[i].e_redir);
      advance();
    end

    // RAS overflow: learn 5 CALLs and 5 RETs without mispredicting, then fetch them.
    set_fetch(1'b0, 32'h0);
    for (int i = 0; i < 5; i++) begin
      set_res(1'b1, 32'h1000 + 32'(16*i), 2, 1'b1, 32'h3000, 1'b1, 32'h3000, 8'h0, 5'd0);
      @(negedge clk); check_model(); advance();
      set_res(1'b1, 32'h1080 + 32'(16*i), 3, 1'b1, 32'h7770, 1'b1, 32'h7770, 8'h0, 5'd0);
      @(negedge clk); check_model(); advance();
    end
    idle_res();
    for (int i = 0; i < 5; i++) begin
      set_fetch(1'b1, 32'h1000 + 32'(16*i));
      @(negedge clk); check_model();
      chk($sformatf("call%0d_f_hit", i), 32'(f_hit), 32'h1);
      advance();
    end
    for (int i = 0; i < 5; i++) begin
      set_fetch(1'b1, 32'h1080 + 32'(16*i));
      @(negedge clk); check_model();
      chk($sformatf("ret%0d_target", i), f_pred_target, ret_exp[i]);
      advance();
    end

    // Fetch BR hit concurrent with a JMP mispredict: recovery GHR wins.
    set_fetch(1'b1, 32'h100);
    set_res(1'b1, 32'h600, 1, 1'b1, 32'h700, 1'b0, 32'h0, 8'h5A, 5'd0);
    @(negedge clk); check_model();
    chk("conc_f_hit", 32'(f_hit), 32'h1);
    chk("conc_mispredict", 32'(mispredict), 32'h1);
    advance();
    set_fetch(1'b0, 32'h0);
    idle_res();
    @(negedge clk); check_model();
    chk("conc_ghr", 32'(f_ghr), 32'h5A);
    advance();

    // Mid-run reset
    nrst = 1'b0;
    set_fetch(1'b1, 32'h100);
    @(negedge clk); check_model(); advance();
    nrst = 1'b1;
    @(negedge clk); check_model();
    chk("rst_f_hit", 32'(f_hit), 32'h0);
    chk("rst_f_pred_target", f_pred_target, 32'h104);
    chk("rst_f_ghr", 32'(f_ghr), 32'h0);
    chk("rst_f_ras_ckpt", 32'(f_ras_ckpt), 32'h0);
    advance();

    // Random traffic against the model
    for (int n = 0; n < 1500; n++) begin
      int typ;
      logic tk;
      logic [31:0] tgt;
      nrst = ($urandom_range(0, 199) != 0);
      set_fetch($urandom_range(0, 3) != 0, pool[$urandom_range(0, 15)]);
      typ = $urandom_range(0, 3);
      tk  = (typ == 0) ? 1'($urandom_range(0, 1)) : 1'b1;
      tgt = pool[$urandom_range(0, 15)];
      set_res(1'($urandom_range(0, 1)), pool[$urandom_range(0, 15)], typ, tk, tgt,
              1'($urandom_range(0, 1)),
              ($urandom_range(0, 1) != 0) ? tgt : pool[$urandom_range(0, 15)],
              8'($urandom_range(0, 255)),
              5'(($urandom_range(0, 4) << 2) | $urandom_range(0, 3)));
      @(negedge clk);
      check_model();
      advance();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bpu_gshare.md
# bpu_gshare

Parametrised next-generation branch prediction unit for the RISC-V fetch stage. It combines three structures: a tagged branch target buffer (BTB) with per-entry control-flow type, a gshare pattern history table (PHT) indexed by PC xor a speculative global history register (GHR), and a circular return address stack (RAS). Prediction is combinational from the fetch PC. Resolution from the execute stage updates the tables, detects mispredictions and restores the speculative state from a checkpoint carried down the pipeline alongside each instruction.

## Interface
- PC_W, 32: PC and target width.
- BTB_LOG, 9: log2 of BTB entries.
- TAG_W, 8: BTB tag width.
- PHT_LOG, 10: log2 of PHT entries.
- GHR_W, 8: global history length; must satisfy GHR_W <= PHT_LOG.
- RAS_DEPTH, 4: RAS entries; must be a power of 2, >= 2.
- RAS_CKPT_W, derived: 2*$clog2(RAS_DEPTH)+1; RAS checkpoint, packed as {cnt, ptr}.

Ports:
- clk  in  1  clock; all state updates on posedge.
- nrst  in  1  reset, synchronous, active-low.
- f_valid  in  1  fetch PC valid this cycle.
- f_pc  in  PC_W  fetch PC.
- f_hit  out  1  BTB tag match with a valid entry.
- f_pred_taken  out  1  predicted redirect.
- f_pred_target  out  PC_W  predicted target.
- f_ghr  out  GHR_W  GHR value used for this prediction (checkpoint).
- f_ras_ckpt  out  RAS_CKPT_W  RAS state before this fetch's push/pop.
- r_valid  in  1  resolve valid.
- r_pc  in  PC_W  resolved instruction PC.
- r_type  in  2  br_type_e: BR, JMP, CALL, RET.
- r_taken  in  1  actual outcome; 1 for every non-BR type.
- r_target  in  PC_W  actual target.
- r_pred_taken, r_pred_target  in  1, PC_W  prediction made at fetch.
- r_ghr, r_ras_ckpt  in  GHR_W, RAS_CKPT_W  checkpoints returned from fetch.
- mispredict  out  1  redirect fetch and flush younger instructions.
- redirect_pc  out  PC_W  r_taken ? r_target : r_pc+4.

## Operation
- Indexing:
  - BTB index = pc[BTB_LOG+1:2].
  - BTB tag = pc[BTB_LOG+TAG_W+1:BTB_LOG+2].
  - PHT index = pc[PHT_LOG+1:2] ^ zero-extended GHR.
- Prediction:
  - f_hit = valid & tag match.
  - On a hit, f_pred_taken = (type==BR) ? PHT[idx][1] : 1.
  - On a miss, f_pred_taken = 0 and f_pred_target = f_pc+4.
  - On a RET hit with RAS cnt>0, f_pred_target = RAS top; otherwise it is the BTB target.
- Speculative fetch update, when f_valid & f_hit and no mispredict in the same cycle:
  - BR: GHR <= {GHR[GHR_W-2:0], f_pred_taken}.
  - CALL: push f_pc+4.
  - RET: pop.
- Mispredict (combinational): r_valid & ((r_taken != r_pred_taken) | (r_taken & r_target != r_pred_target)).
- Recovery on mispredict:
  - GHR <= (r_type==BR) ? {r_ghr[GHR_W-2:0], r_taken} : r_ghr.
  - RAS {cnt, ptr} <= r_ras_ckpt, then the resolved CALL push or RET pop is reapplied.
- Table update on every r_valid:
  - PHT[r_pc ^ r_ghr] is updated with a 2-bit saturating counter for BR only.
  - If r_taken, the BTB entry is written: valid, tag, r_target, r_type. This covers allocation and overwrite.
  - A not-taken BR never allocates.
- RAS boundaries:
  - Push when full overwrites the oldest entry; ptr wraps and cnt saturates at RAS_DEPTH.
  - Pop when empty is a no-op.

## Timing
- Prediction outputs are combinational from f_pc and current state, in the same cycle.
- mispredict and redirect_pc are combinational from the r_* inputs, in the same cycle.
- Table, GHR and RAS writes take effect at the next posedge and are visible to the next cycle's fetch.
- Same-cycle BTB/PHT write and read at one index: the fetch sees the old value. There is no bypass.
- Mispredict concurrent with a fetch hit: recovery wins and the fetch's speculative GHR/RAS update is dropped.
- Reset, including mid-operation, in one cycle:
  - All BTB valid bits 0; PHT entries 2'b01; GHR 0; RAS cnt/ptr 0.
  - Outputs after reset: f_hit=0, f_pred_taken=0, f_pred_target=f_pc+4, mispredict=0 if r_valid=0.

## Structure
- Package bpu_pkg holds br_type_e (BR=0, JMP=1, CALL=2, RET=3) and the 2-bit counter update function sat2_next.
- Sub-module bpu_ras: circular stack with push, pop, ckpt_out, restore, restore_val and top. It is instantiated once.
- The BTB and PHT are flop arrays inside bpu_gshare.

## Test plan
- Reset, then f_pc=0x100 -> f_hit=0, f_pred_taken=0, f_pred_target=0x104, f_ghr=0.
- Resolve BR at r_pc=0x100 (taken, r_target=0x80, r_pred_taken=0, r_ghr=0):
  - Same cycle: mispredict=1, redirect_pc=0x80.
  - Next cycle: GHR=0x01, PHT[0x40]=2'b10.
  - Fetch 0x100: f_hit=1, PHT index 0x41 still 01, so f_pred_taken=0.
- Learn CALL 0x200->0x400 and RET 0x480->0x0:
  - Fetch 0x200 -> f_pred_target=0x400, RAS top=0x204.
  - Fetch 0x480 -> f_pred_target=0x204.
- RAS_DEPTH=4, five learned CALL fetches then five RET fetches:
  - The first four predict the return addresses newest-first.
  - The fifth falls back to the BTB target.
- Fetch hit on a BR in the same cycle as a JMP mispredict with r_ghr=0x5A -> GHR=0x5A next cycle, with no fetch shift.
- Allocate 0x100, then fetch 0x100+(1<<(BTB_LOG+2)) -> f_hit=0 (tag mismatch).
